// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two-port arbiter sharing one combinational ALU. Each accepted
//            operation runs IDLE -> EXEC -> RESP and holds its response until
//            the consumer takes it. Defining ALU_ARB_ROUND_ROBIN_EN selects
//            round-robin contention. Left undefined, port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [3:0]       op0,
    input  logic [3:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    input  logic             rsp_ready,
    output logic             busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0] r_state;
    logic       r_last;     // index of the port granted most recently
    logic       w_idle;
    logic       w_prio0;
    logic       w_illegal;

    assign w_idle = (r_state == c_st_idle);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    assign w_prio0 = r_last;
`else
    // The pointer is still tracked but can never change the outcome here.
    assign w_prio0 = r_last | 1'b1;
`endif

    assign gnt0 = rst_n & w_idle & req0 & (~req1 | w_prio0);
    assign gnt1 = rst_n & w_idle & req1 & (~req0 | ~w_prio0);

    always_comb begin
        w_illegal = 1'b1;
        case (alu_ctl)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b1000, 4'b1001, 4'b1011: w_illegal = 1'b0;
            default:                   w_illegal = 1'b1;
        endcase
    end

    assign rsp_valid = (r_state == c_st_resp);
    assign busy      = ~w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_last   <= 1'b1;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctl  <= 4'b0000;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (gnt0 | gnt1) begin
                        r_state <= c_st_exec;
                        r_last  <= gnt1;
                        rsp_id  <= gnt1;
                        alu_ctl <= gnt1 ? op1 : op0;
                        alu_a   <= gnt1 ? a1  : a0;
                        alu_b   <= gnt1 ? b1  : b0;
                    end
                end
                c_st_exec: begin
                    r_state  <= c_st_resp;
                    rsp_err  <= w_illegal;
                    rsp_data <= w_illegal ? '0 : alu_result;
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with a reference
//            ALU model on the shared-ALU port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1;
    logic [3:0]       op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid, rsp_id, rsp_err, rsp_ready, busy;
    logic [WIDTH-1:0] rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared ALU; illegal codes return garbage so zeroing is observable.
    always_comb begin
        case (alu_ctl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1000: alu_result = alu_a << alu_b[4:0];
            4'b1001: alu_result = alu_a >> alu_b[4:0];
            4'b1011: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    logic exp_id;

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req0 = 1'b1; op0 = 4'b0010; a0 = 32'd5; b0 = 32'd7;
        req1 = 1'b0; op1 = 4'b0000; a1 = '0;    b1 = '0;

        // Reset state, with a request already pending
        tick();
        tick();
        check("rst_gnt0",    32'(gnt0), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_valid",   32'(rsp_valid), 32'd0);
        check("rst_alu_ctl", 32'(alu_ctl), 32'd0);
        check("rst_alu_a",   alu_a, 32'd0);
        check("rst_data",    rsp_data, 32'd0);

        // Basic ADD from port 0: grant cycle 1, response cycle 3
        rst_n = 1'b1;
        #1;
        check("c1_gnt0", 32'(gnt0), 32'd1);
        check("c1_gnt1", 32'(gnt1), 32'd0);
        tick();
        check("c2_busy",    32'(busy), 32'd1);
        check("c2_gnt0",    32'(gnt0), 32'd0);
        check("c2_alu_a",   alu_a, 32'd5);
        check("c2_alu_b",   alu_b, 32'd7);
        check("c2_alu_ctl", 32'(alu_ctl), 32'd2);
        check("c2_valid",   32'(rsp_valid), 32'd0);
        req0 = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("c3_valid", 32'(rsp_valid), 32'd1);
        check("c3_busy",  32'(busy), 32'd1);
        check("c3_id",    32'(rsp_id), 32'd0);
        check("c3_data",  rsp_data, 32'd12);
        check("c3_err",   32'(rsp_err), 32'd0);
        tick();
        check("c4_valid", 32'(rsp_valid), 32'd0);
        check("c4_busy",  32'(busy), 32'd0);

        // Continuous contention, SUB on both ports
        do_reset();
        req0 = 1'b1; op0 = 4'b0110; a0 = 32'd9;  b0 = 32'd3;
        req1 = 1'b1; op1 = 4'b0110; a1 = 32'd20; b1 = 32'd5;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            exp_id = k[0];
`else
            exp_id = 1'b0;
`endif
            check("cont_gnt0", 32'(gnt0), 32'(!exp_id));
            check("cont_gnt1", 32'(gnt1), 32'(exp_id));
            tick();
            check("cont_exec_nogrant", 32'(gnt0 | gnt1), 32'd0);
            tick();
            check("cont_id",   32'(rsp_id), 32'(exp_id));
            check("cont_data", rsp_data, exp_id ? 32'd15 : 32'd6);
            tick();
            #1;
        end

        // Back-pressure: port 1 shift held 5 cycles while port 0 waits
        req0 = 1'b0;
        req1 = 1'b1; op1 = 4'b1000; a1 = 32'd1; b1 = 32'd4;
        rsp_ready = 1'b0;
        #1;
        check("bp_gnt1", 32'(gnt1), 32'd1);
        tick();
        req1 = 1'b0;
        req0 = 1'b1; op0 = 4'b0010; a0 = 32'd2; b0 = 32'd3;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data",  rsp_data, 32'd16);
            check("bp_id",    32'(rsp_id), 32'd1);
            check("bp_nogrant", 32'(gnt0 | gnt1), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_hs_valid", 32'(rsp_valid), 32'd1);
        tick();
        check("bp_next_gnt0", 32'(gnt0), 32'd1);
        tick();
        req0 = 1'b0;
        tick();
        check("bp_next_data", rsp_data, 32'd5);
        check("bp_next_id",   32'(rsp_id), 32'd0);
        tick();

        // Illegal op code
        req0 = 1'b1; op0 = 4'b0111; a0 = 32'd3; b0 = 32'd4;
        #1;
        check("ill_gnt0", 32'(gnt0), 32'd1);
        tick();
        req0 = 1'b0;
        tick();
        check("ill_err",  32'(rsp_err), 32'd1);
        check("ill_data", rsp_data, 32'd0);
        check("ill_id",   32'(rsp_id), 32'd0);
        tick();

        // Asynchronous reset while in EXEC
        req0 = 1'b1; op0 = 4'b0000; a0 = 32'hF0; b0 = 32'h3C;
        #1;
        check("ar_gnt0", 32'(gnt0), 32'd1);
        tick();
        check("ar_busy_exec", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy",    32'(busy), 32'd0);
        check("ar_gnt0_rst", 32'(gnt0), 32'd0);
        check("ar_alu_a",   alu_a, 32'd0);
        check("ar_alu_ctl", 32'(alu_ctl), 32'd0);
        check("ar_valid",   32'(rsp_valid), 32'd0);
        req0 = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("ar_post_valid", 32'(rsp_valid), 32'd0);
            check("ar_post_busy",  32'(busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  the single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req0 / req1  input  1  requester 0/1 has an operation pending.
REQ-005 op0 / op1  input  4  ALU control code of requester 0/1.
REQ-006 a0, b0 / a1, b1  input  WIDTH  operands of requester 0/1.
REQ-007 gnt0 / gnt1  output  1  one-cycle grant; request accepted this cycle.
REQ-008 alu_a, alu_b  output  WIDTH  registered operands driven to the shared ALU.
REQ-009 alu_ctl  output  4  registered control code driven to the shared ALU.
REQ-010 alu_result  input  WIDTH  combinational result returned by the shared ALU.
REQ-011 rsp_valid  output  1  response held for the requester.
REQ-012 rsp_id  output  1  requester index that owns the response.
REQ-013 rsp_data  output  WIDTH  captured ALU result.
REQ-014 rsp_err  output  1  op code was illegal.
REQ-015 rsp_ready  input  1  response consumer accepts rsp_* this cycle.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, EXEC, RESP; IDLE->EXEC on any grant, EXEC->RESP unconditionally, RESP->IDLE on rsp_valid & rsp_ready, otherwise hold RESP.
REQ-018 Grants combinational, only in IDLE; at most one of gnt0/gnt1 high; gnt deasserted in EXEC and RESP regardless of req.
REQ-019 On a grant edge, capture granted op/a/b into alu_ctl/alu_a/alu_b and index into rsp_id; these registers hold until the next grant.
REQ-020 In EXEC, rsp_data <= alu_result and rsp_err <= (alu_ctl not in {0000,0001,0010,0110,1000,1001,1011}); on rsp_err, rsp_data <= 0 instead.
REQ-021 rsp_valid high exactly in RESP; rsp_data, rsp_id, rsp_err stable while rsp_valid & !rsp_ready.
REQ-022 Latency: grant in cycle N, rsp_valid first high in cycle N+2; no new grant before the cycle after the response handshake (min issue interval 3 cycles).
REQ-023 Requesters hold req and operands until their gnt; a req dropped before grant is simply not serviced.
REQ-024 Only one request: that port is granted, independent of arbitration history.
REQ-025 Both requesting: arbitration per Configuration; last-granted pointer updates on every grant.

Reset
REQ-026 rst_n low asynchronously forces IDLE, gnt0/gnt1 0, rsp_valid 0, rsp_err 0, rsp_id 0, rsp_data 0, alu_a/alu_b 0, alu_ctl 0000, busy 0, last-granted pointer = 1 (port 0 wins first contention).
REQ-027 Reset asserted mid-operation (EXEC or RESP) discards the operation; no response is produced after release.
REQ-028 First grant possible in the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro ALU_ARB_ROUND_ROBIN_EN defined: on contention, grant the port not granted last (strict alternation under continuous contention).
REQ-030 Macro undefined: fixed priority, port 0 always wins contention; last-granted pointer still maintained but unused.

Verification
REQ-031 Reset, then req0=1 op0=0010 a0=5 b0=7 -> gnt0 cycle 1, rsp_valid cycle 3 with rsp_id=0 rsp_data=12 rsp_err=0, busy high cycles 2-3.
REQ-032 req0 and req1 held high, rsp_ready=1, op=0110 each -> with macro grants alternate 0,1,0,1 every 3 cycles; without macro only gnt0 ever asserts.
REQ-033 req1 op1=1000 a1=1 b1=4, rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data=16 stable, no gnt while req0 also pending; handshake then gnt0 the following cycle.
REQ-034 req0 op0=0111 -> rsp_err=1, rsp_data=0, rsp_id=0.
REQ-035 rst_n pulled low while in EXEC -> all outputs 0 immediately (before next edge), no rsp_valid after release until a new grant.
